// File: rtl/fixed_mul_pipe.sv
// rtl/fixed_mul_pipe.sv - pipelined Qm.FRAC fixed-point multiplier with round/saturate and valid/ready
module fixed_mul_pipe #(
   parameter int WIDTH  = 20,
   parameter int FRAC   = 10,
   parameter int STAGES = 3,
   parameter int SIGNED = 1,
   parameter int ROUND  = 1,
   parameter int SAT    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] mulout,
   output logic             ovf
);

   // One guard bit above 2*WIDTH keeps the rounding add from wrapping in either mode.
   localparam int PW = 2*WIDTH + 1;
   localparam logic signed [PW-1:0] RMAX = (SIGNED != 0) ? (PW'(1) <<< (WIDTH-1)) - PW'(1)
                                                         : (PW'(1) <<< WIDTH) - PW'(1);
   localparam logic signed [PW-1:0] RMIN = (SIGNED != 0) ? -(PW'(1) <<< (WIDTH-1)) : '0;
   localparam logic signed [PW-1:0] RND  = (ROUND != 0) ? (PW'(1) <<< (FRAC-1)) : '0;

   logic signed [PW-1:0] a_ext, b_ext, prod, rnd_sum, r;
   logic [WIDTH-1:0]     res;
   logic                 res_ovf;
   logic                 en;

   logic [STAGES-1:0]    vld;
   logic [STAGES-1:0]    ofl;
   logic [WIDTH-1:0]     dat [STAGES];

   always_comb begin
      if (SIGNED != 0) begin
         a_ext = {{(WIDTH+1){in1[WIDTH-1]}}, in1};
         b_ext = {{(WIDTH+1){in2[WIDTH-1]}}, in2};
      end else begin
         a_ext = {{(WIDTH+1){1'b0}}, in1};
         b_ext = {{(WIDTH+1){1'b0}}, in2};
      end
      prod    = a_ext * b_ext;
      rnd_sum = prod + RND;
      r       = rnd_sum >>> FRAC;
      res_ovf = (r > RMAX) || (r < RMIN);
      res     = r[WIDTH-1:0];
      if (res_ovf && (SAT != 0)) begin
         res = (r > RMAX) ? RMAX[WIDTH-1:0] : RMIN[WIDTH-1:0];
      end
   end

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out_valid = vld[STAGES-1];
   assign mulout    = dat[STAGES-1];
   assign ovf       = ofl[STAGES-1];

   // Data registers load only behind a valid bit, so outputs hold their last result across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         ofl <= '0;
         for (int i = 0; i < STAGES; i++) begin
            dat[i] <= '0;
         end
      end else if (en) begin
         vld[0] <= in_valid;
         if (in_valid) begin
            dat[0] <= res;
            ofl[0] <= res_ovf;
         end
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) begin
               dat[i] <= dat[i-1];
               ofl[i] <= ofl[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// tb/tb_fixed_mul_pipe.sv - directed and streaming checks for fixed_mul_pipe
module tb_fixed_mul_pipe;

   typedef struct {
      logic [19:0] a;
      logic [19:0] b;
      int          cfg;   // 0 default, 1 truncate, 2 wrap, 3 unsigned/1-stage
      logic [19:0] exp;
      logic        eovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [19:0] in1 = '0, in2 = '0;

   logic        rdy0, rdy1, rdy2, rdy3;
   logic        ov0, ov1, ov2, ov3;
   logic [19:0] m0, m1, m2, m3;
   logic        f0, f1, f2, f3;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fixed_mul_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in1(in1), .in2(in2),
      .out_valid(ov0), .out_ready(out_ready), .mulout(m0), .ovf(f0));
   fixed_mul_pipe #(.ROUND(0)) dut_trunc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in1(in1), .in2(in2),
      .out_valid(ov1), .out_ready(out_ready), .mulout(m1), .ovf(f1));
   fixed_mul_pipe #(.SAT(0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in1(in1), .in2(in2),
      .out_valid(ov2), .out_ready(out_ready), .mulout(m2), .ovf(f2));
   fixed_mul_pipe #(.SIGNED(0), .STAGES(1)) dut_uns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in1(in1), .in2(in2),
      .out_valid(ov3), .out_ready(out_ready), .mulout(m3), .ovf(f3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Independent reference: exact integer product, round-half-up, then range test (ROUND=1, SAT=1).
   function automatic void ref_mul(input logic [19:0] a, input logic [19:0] b, input bit sgn,
                                   output logic [19:0] res, output logic o);
      longint sa, sb, p, r, hi, lo;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         hi = 524287;
         lo = -524288;
      end else begin
         sa = longint'({44'd0, a});
         sb = longint'({44'd0, b});
         hi = 1048575;
         lo = 0;
      end
      p = sa * sb + 512;
      r = p >>> 10;
      o = (r > hi) || (r < lo);
      if (r > hi)      res = hi[19:0];
      else if (r < lo) res = lo[19:0];
      else             res = r[19:0];
   endfunction

   task automatic sel(input int cfg, output logic v, output logic [19:0] d, output logic o);
      case (cfg)
         1:       begin v = ov1; d = m1; o = f1; end
         2:       begin v = ov2; d = m2; o = f2; end
         3:       begin v = ov3; d = m3; o = f3; end
         default: begin v = ov0; d = m0; o = f0; end
      endcase
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int          n;
      logic        gv, go;
      logic [19:0] gd;
      in1 = v.a; in2 = v.b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      sel(v.cfg, gv, gd, go);
      while (!gv && n < 20) begin
         @(posedge clk); #1;
         n++;
         sel(v.cfg, gv, gd, go);
      end
      chk({name, " latency"}, n, (v.cfg == 3) ? 1 : 3);
      chk({name, " mulout"}, {12'd0, gd}, {12'd0, v.exp});
      chk({name, " ovf"}, {31'd0, go}, {31'd0, v.eovf});
      repeat (4) @(posedge clk);
      #1;
   endtask

   vec_t        vecs [17];
   logic [19:0] qd [$];
   logic        qo [$];
   logic [19:0] qud [$];
   logic        quo [$];

   initial begin
      logic [19:0] ed, held, ra, rb;
      logic        eo;
      int          got, got_u;

      vecs[0]  = '{20'h00600, 20'h00800, 0, 20'h00C00, 1'b0};
      vecs[1]  = '{20'hFFA00, 20'h00800, 0, 20'hFF400, 1'b0};
      vecs[2]  = '{20'h00001, 20'h00200, 0, 20'h00001, 1'b0};
      vecs[3]  = '{20'h00001, 20'h00200, 1, 20'h00000, 1'b0};
      vecs[4]  = '{20'hFFFFF, 20'h00200, 0, 20'h00000, 1'b0};
      vecs[5]  = '{20'hFFFFF, 20'h00200, 1, 20'hFFFFF, 1'b0};
      vecs[6]  = '{20'h4B000, 20'h00800, 0, 20'h7FFFF, 1'b1};
      vecs[7]  = '{20'hB5000, 20'h00800, 0, 20'h80000, 1'b1};
      vecs[8]  = '{20'h4B000, 20'h00800, 2, 20'h96000, 1'b1};
      vecs[9]  = '{20'hB5000, 20'h00800, 2, 20'h6A000, 1'b1};
      vecs[10] = '{20'h40100, 20'h007FE, 0, 20'h7FFFF, 1'b1};
      vecs[11] = '{20'h40100, 20'h007FE, 1, 20'h7FFFF, 1'b0};
      vecs[12] = '{20'h40100, 20'h007FE, 2, 20'h80000, 1'b1};
      vecs[13] = '{20'h7FFFF, 20'h00400, 0, 20'h7FFFF, 1'b0};
      vecs[14] = '{20'h80000, 20'h00400, 0, 20'h80000, 1'b0};
      vecs[15] = '{20'hFFFFF, 20'h00800, 3, 20'hFFFFF, 1'b1};
      vecs[16] = '{20'h80000, 20'h00400, 3, 20'h80000, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset out_valid", {31'd0, ov0}, 32'd0);
      chk("reset mulout", {12'd0, m0}, 32'd0);
      chk("reset ovf", {31'd0, f0}, 32'd0);
      chk("reset in_ready", {31'd0, rdy0}, 32'd1);

      for (int i = 0; i < 17; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // Backpressure: 10 back-to-back pairs, out_ready low for cycles 5..9.
      got = 0;
      held = '0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         in_valid  = (qd.size() + got) < 10;
         out_ready = !(c >= 5 && c <= 9);
         if (in_valid) begin
            in1 = 20'($urandom);
            in2 = 20'($urandom);
         end
         #1;
         if (c >= 6 && c <= 9) begin
            chk($sformatf("stall in_ready c%0d", c), {31'd0, rdy0}, 32'd0);
            chk($sformatf("stall mulout c%0d", c), {12'd0, m0}, {12'd0, held});
         end
         if (in_valid && rdy0) begin
            ref_mul(in1, in2, 1'b1, ed, eo);
            qd.push_back(ed);
            qo.push_back(eo);
         end
         if (ov0 && out_ready) begin
            if (qd.size() == 0) chk("bp unexpected result", 32'd1, 32'd0);
            else begin
               ed = qd.pop_front();
               eo = qo.pop_front();
               chk($sformatf("bp result%0d", got), {11'd0, f0, m0}, {11'd0, eo, ed});
            end
            got++;
         end
         held = m0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp result count", got, 10);
      qd.delete();
      qo.delete();
      repeat (4) @(posedge clk);
      #1;

      // Reset with three pairs in flight.
      for (int k = 0; k < 3; k++) begin
         in1 = 20'($urandom); in2 = 20'($urandom); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst out_valid", {31'd0, ov0}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst stale c%0d", k), {31'd0, ov0}, 32'd0);
      end
      run_vec("post-reset", vecs[0]);

      // Throughput: 100 consecutive pairs into both the default and unsigned/1-stage instances.
      got = 0;
      got_u = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 106; c++) begin
         in_valid = (c < 100);
         ra = 20'($urandom);
         rb = 20'($urandom);
         in1 = ra; in2 = rb;
         #1;
         if (ov0) begin
            if (qd.size() == 0) chk("tp unexpected result", 32'd1, 32'd0);
            else begin
               ed = qd.pop_front();
               eo = qo.pop_front();
               chk($sformatf("tp signed%0d", got), {11'd0, f0, m0}, {11'd0, eo, ed});
            end
            got++;
         end
         if (ov3) begin
            if (qud.size() == 0) chk("tp uns unexpected result", 32'd1, 32'd0);
            else begin
               ed = qud.pop_front();
               eo = quo.pop_front();
               chk($sformatf("tp unsigned%0d", got_u), {11'd0, f3, m3}, {11'd0, eo, ed});
            end
            got_u++;
         end
         if (in_valid && rdy0) begin
            ref_mul(ra, rb, 1'b1, ed, eo);
            qd.push_back(ed);
            qo.push_back(eo);
            ref_mul(ra, rb, 1'b0, ed, eo);
            qud.push_back(ed);
            quo.push_back(eo);
         end
         if (c == 100) chk("tp unsigned count at 100", got_u, 100);
         if (c == 101) chk("tp signed count at 101", got, 99);
         if (c == 102) chk("tp signed count at 102", got, 100);
         @(posedge clk); #1;
      end
      chk("tp signed final count", got, 100);
      chk("tp unsigned final count", got_u, 100);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
